// File: rtl/trace_pkg.sv
// Shared definitions for the CPU commit trace buffer: FSM state encoding,
// trace entry width, rd_data field offsets and entry pack/unpack helpers.
// Entry layout, MSB to LSB: {pc, instr, wen, waddr, wdata}.
package trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_TRIGGERED = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   // Widest configuration the pack/unpack helpers can carry.
   localparam int XLEN_MAX  = 64;
   localparam int RAW_MAX   = 8;
   localparam int ENTRY_MAX = 3 * XLEN_MAX + 1 + RAW_MAX;

   function automatic int entry_w(int xlen, int raw);
      return 3 * xlen + 1 + raw;
   endfunction

   function automatic int off_waddr(int xlen);
      return xlen;
   endfunction

   function automatic int off_wen(int xlen, int raw);
      return xlen + raw;
   endfunction

   function automatic int off_instr(int xlen, int raw);
      return xlen + raw + 1;
   endfunction

   function automatic int off_pc(int xlen, int raw);
      return 2 * xlen + raw + 1;
   endfunction

   // Narrow fields are passed zero-extended, so OR-ing them into place is safe.
   function automatic logic [ENTRY_MAX-1:0] pack_entry(
      int xlen, int raw,
      logic [XLEN_MAX-1:0] pc, logic [XLEN_MAX-1:0] instr,
      logic wen, logic [RAW_MAX-1:0] waddr, logic [XLEN_MAX-1:0] wdata);
      logic [ENTRY_MAX-1:0] e;
      e = ENTRY_MAX'(wdata);
      e = e | (ENTRY_MAX'(waddr) << off_waddr(xlen));
      e = e | (ENTRY_MAX'(wen)   << off_wen(xlen, raw));
      e = e | (ENTRY_MAX'(instr) << off_instr(xlen, raw));
      e = e | (ENTRY_MAX'(pc)    << off_pc(xlen, raw));
      return e;
   endfunction

   function automatic logic [XLEN_MAX-1:0] xmask(int xlen);
      return (XLEN_MAX'(1) << xlen) - XLEN_MAX'(1);
   endfunction

   function automatic logic [XLEN_MAX-1:0] unpack_pc(logic [ENTRY_MAX-1:0] e, int xlen, int raw);
      return XLEN_MAX'(e >> off_pc(xlen, raw)) & xmask(xlen);
   endfunction

   function automatic logic [XLEN_MAX-1:0] unpack_instr(logic [ENTRY_MAX-1:0] e, int xlen, int raw);
      return XLEN_MAX'(e >> off_instr(xlen, raw)) & xmask(xlen);
   endfunction

   function automatic logic unpack_wen(logic [ENTRY_MAX-1:0] e, int xlen, int raw);
      return e[off_wen(xlen, raw)];
   endfunction

   function automatic logic [RAW_MAX-1:0] unpack_waddr(logic [ENTRY_MAX-1:0] e, int xlen, int raw);
      return RAW_MAX'(e >> off_waddr(xlen)) & ((RAW_MAX'(1) << raw) - RAW_MAX'(1));
   endfunction

   function automatic logic [XLEN_MAX-1:0] unpack_wdata(logic [ENTRY_MAX-1:0] e, int xlen);
      return XLEN_MAX'(e) & xmask(xlen);
   endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Commit input bus and trace readout stream of the CPU trace buffer.
// slave: the trace buffer; master: the CPU write-back stage plus debug host.
interface cpu_trace_buffer_if import trace_pkg::*; #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
);
   logic                          cm_valid;
   logic [XLEN-1:0]               cm_pc;
   logic [XLEN-1:0]               cm_instr;
   logic                          cm_wen;
   logic [RAW-1:0]                cm_waddr;
   logic [XLEN-1:0]               cm_wdata;
   logic                          rd_ready;
   logic                          rd_valid;
   logic [entry_w(XLEN, RAW)-1:0] rd_data;
   logic                          rd_last;

   modport master (
      output cm_valid, cm_pc, cm_instr, cm_wen, cm_waddr, cm_wdata, rd_ready,
      input  rd_valid, rd_data, rd_last
   );

   modport slave (
      input  cm_valid, cm_pc, cm_instr, cm_wen, cm_waddr, cm_wdata, rd_ready,
      output rd_valid, rd_data, rd_last
   );
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Read data holds its value while re is low.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 101
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Capture write port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read, advanced only when the readout fetches a new entry.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU commit trace buffer: circular capture of commit records, PC-match
// trigger with post-trigger count, oldest-first readout over valid/ready.
// Optional build macro TRACE_WB_FILTER_EN adds filt_wb_only, which restricts
// capture to commits that write a non-zero register (trigger commit always kept).
module cpu_trace_buffer import trace_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int RAW   = 5,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     arm,
   input  logic [XLEN-1:0]          trig_pc,
   input  logic [$clog2(DEPTH):0]   post_cnt,
`ifdef TRACE_WB_FILTER_EN
   input  logic                     filt_wb_only,
`endif
   cpu_trace_buffer_if.slave        bus,
   output logic [1:0]               state,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     trig_hit
);
   localparam int             AW      = $clog2(DEPTH);
   localparam int             ENTRY_W = entry_w(XLEN, RAW);
   localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]    ONE     = (AW+1)'(1);

   state_t              fsm;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         remain;
   logic [AW:0]         fetch_left;
   logic                rd_valid_r;
   logic                rd_last_r;
   logic [ENTRY_W-1:0]  wr_entry;
   logic [ENTRY_W-1:0]  ram_q;
   logic                capturing;
   logic                is_trig;
   logic                keep;
   logic                record;
   logic                xfer;
   logic                fetch;
   logic [AW:0]         eff;
   logic [AW:0]         count_nx;
   logic [AW-1:0]       wr_ptr_nx;
   logic [AW-1:0]       start_ptr;

   assign capturing = (fsm == ST_ARMED) || (fsm == ST_TRIGGERED);
   // Only the first match counts: later matches in TRIGGERED are plain commits.
   assign is_trig   = (fsm == ST_ARMED) && bus.cm_valid && (bus.cm_pc == trig_pc);

`ifdef TRACE_WB_FILTER_EN
   assign keep = !filt_wb_only || (bus.cm_wen && (bus.cm_waddr != '0)) || is_trig;
`else
   assign keep = 1'b1;
`endif

   // arm wins over a simultaneous commit, so the write is suppressed too.
   assign record    = capturing && bus.cm_valid && keep && !arm;
   assign count_nx  = (count == DEPTH_C) ? count : count + ONE;
   assign wr_ptr_nx = wr_ptr + 1'b1;
   // A full buffer has wrapped: its oldest entry sits where the next write would go.
   assign start_ptr = (count_nx == DEPTH_C) ? wr_ptr_nx : '0;

   assign xfer  = rd_valid_r && bus.rd_ready;
   assign fetch = (fsm == ST_DONE) && (fetch_left != '0) && (!rd_valid_r || xfer) && !arm;

   assign wr_entry = ENTRY_W'(pack_entry(XLEN, RAW,
                                         XLEN_MAX'(bus.cm_pc), XLEN_MAX'(bus.cm_instr),
                                         bus.cm_wen, RAW_MAX'(bus.cm_waddr),
                                         XLEN_MAX'(bus.cm_wdata)));

   assign state        = fsm;
   assign bus.rd_valid = rd_valid_r;
   assign bus.rd_last  = rd_last_r;
   assign bus.rd_data  = rd_valid_r ? ram_q : '0;

   // Post-trigger length clamped to 1..DEPTH (0 behaves as 1).
   always_comb begin
      eff = post_cnt;
      if (post_cnt == '0) eff = ONE;
      else if (post_cnt > DEPTH_C) eff = DEPTH_C;
   end

   trace_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_ram (
      .clk   (clk),
      .we    (record),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .re    (fetch),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );

   // Capture/trigger/readout control FSM with registered status and stream flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= ST_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         remain     <= '0;
         fetch_left <= '0;
         trig_hit   <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_last_r  <= 1'b0;
      end else if (arm) begin
         fsm        <= ST_ARMED;
         wr_ptr     <= '0;
         count      <= '0;
         remain     <= '0;
         fetch_left <= '0;
         trig_hit   <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_last_r  <= 1'b0;
      end else begin
         unique case (fsm)
            ST_IDLE: begin
            end
            ST_ARMED: begin
               if (record) begin
                  wr_ptr <= wr_ptr_nx;
                  count  <= count_nx;
                  if (is_trig) begin
                     trig_hit <= 1'b1;
                     remain   <= eff - ONE;
                     if (eff == ONE) begin
                        fsm        <= ST_DONE;
                        rd_ptr     <= start_ptr;
                        fetch_left <= count_nx;
                     end else begin
                        fsm <= ST_TRIGGERED;
                     end
                  end
               end
            end
            ST_TRIGGERED: begin
               if (record) begin
                  wr_ptr <= wr_ptr_nx;
                  count  <= count_nx;
                  remain <= remain - ONE;
                  if (remain == ONE) begin
                     fsm        <= ST_DONE;
                     rd_ptr     <= start_ptr;
                     fetch_left <= count_nx;
                  end
               end
            end
            ST_DONE: begin
               if (fetch) begin
                  rd_ptr     <= rd_ptr + 1'b1;
                  fetch_left <= fetch_left - ONE;
                  rd_valid_r <= 1'b1;
                  rd_last_r  <= (fetch_left == ONE);
               end else if (xfer) begin
                  rd_valid_r <= 1'b0;
                  rd_last_r  <= 1'b0;
               end
            end
            default: begin
               fsm <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: randomized commit streams against a queue-based
// reference model; a monitor process checks every readout transfer.
module tb_cpu_trace_buffer;
   localparam int XLEN  = 32;
   localparam int RAW   = 5;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int EW    = 3 * XLEN + 1 + RAW;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            wen;
      logic [RAW-1:0]  waddr;
      logic [XLEN-1:0] wdata;
   } rec_t;

   typedef struct {
      logic [EW-1:0] data;
      logic          last;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            arm = 1'b0;
   logic [XLEN-1:0] trig_pc = '0;
   logic [AW:0]     post_cnt = '0;
   logic            filt = 1'b0;
   logic [1:0]      state;
   logic [AW:0]     count;
   logic            trig_hit;

   int   errors = 0;
   int   checks = 0;
   int   ready_mode = 0;

   exp_t exp_q[$];
   rec_t m_buf[$];
   bit   m_active = 0;
   bit   m_trig = 0;
   int   m_left = 0;

   logic          mon_stall = 1'b0;
   logic [EW-1:0] mon_data = '0;
   logic          mon_last = 1'b0;

   always #5 clk = ~clk;

   cpu_trace_buffer_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

   cpu_trace_buffer #(.XLEN(XLEN), .RAW(RAW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .arm          (arm),
      .trig_pc      (trig_pc),
      .post_cnt     (post_cnt),
`ifdef TRACE_WB_FILTER_EN
      .filt_wb_only (filt),
`endif
      .bus          (bus),
      .state        (state),
      .count        (count),
      .trig_hit     (trig_hit)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: keep the last DEPTH recorded commits; once the trigger
   // has been seen and eff entries (trigger included) are kept, publish them.
   task automatic model_step(input rec_t r);
      bit hit;
      bit rec;
      exp_t e;
      if (!m_active) return;
      hit = !m_trig && (r.pc == trig_pc);
      rec = !filt || (r.wen && r.waddr != '0) || hit;
      if (rec) begin
         m_buf.push_back(r);
         if (m_buf.size() > DEPTH) m_buf.delete(0);
      end
      if (hit) begin
         m_trig = 1;
         if (post_cnt == 0) m_left = 1;
         else if (int'(post_cnt) > DEPTH) m_left = DEPTH;
         else m_left = int'(post_cnt);
      end
      if (m_trig && rec) m_left--;
      if (m_trig && m_left == 0) begin
         m_active = 0;
         for (int i = 0; i < m_buf.size(); i++) begin
            e.data = {m_buf[i].pc, m_buf[i].instr, m_buf[i].wen, m_buf[i].waddr, m_buf[i].wdata};
            e.last = (i == m_buf.size() - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic commit(input logic [XLEN-1:0] pc, input logic wen, input logic [RAW-1:0] waddr);
      rec_t r;
      r.pc = pc; r.instr = $urandom; r.wen = wen; r.waddr = waddr; r.wdata = $urandom;
      bus.cm_valid = 1'b1;
      bus.cm_pc = r.pc; bus.cm_instr = r.instr; bus.cm_wen = r.wen;
      bus.cm_waddr = r.waddr; bus.cm_wdata = r.wdata;
      model_step(r);
      tick();
      bus.cm_valid = 1'b0;
      bus.cm_pc = trig_pc;
      bus.cm_instr = $urandom;
      bus.cm_wdata = $urandom;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      m_active = 1; m_trig = 0; m_left = 0;
      m_buf.delete();
      tick();
      arm = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (state != 2'd3 && n < 100) begin tick(); n++; end
      check(name, state, 2'd3);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || bus.rd_valid) && n < 2000) begin tick(); n++; end
      check({name, "_left"}, exp_q.size(), 0);
      check({name, "_valid"}, bus.rd_valid, 1'b0);
      check({name, "_state"}, state, 2'd3);
   endtask

   // Consumer ready pattern.
   initial begin
      bus.rd_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: bus.rd_ready = 1'b1;
            1: bus.rd_ready = ~bus.rd_ready;
            2: bus.rd_ready = 1'($urandom_range(0, 1));
            default: bus.rd_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pop the scoreboard on each transfer; stalled data must hold.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst || arm) begin
            mon_stall = 1'b0;
         end else if (mon_stall) begin
            check("stall_valid", bus.rd_valid, 1'b1);
            check("stall_data", bus.rd_data, mon_data);
            check("stall_last", bus.rd_last, mon_last);
         end
         if (!rst && bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_entry: got %0h expected no transfer", bus.rd_data);
            end else begin
               e = exp_q.pop_front();
               check("rd_data", bus.rd_data, e.data);
               check("rd_last", bus.rd_last, e.last);
            end
         end
         if (!(rst || arm)) mon_stall = bus.rd_valid && !bus.rd_ready;
         mon_data = bus.rd_data;
         mon_last = bus.rd_last;
      end
   end

   initial begin
      int n;
      bus.cm_valid = 1'b0; bus.cm_pc = '0; bus.cm_instr = '0;
      bus.cm_wen = 1'b0; bus.cm_waddr = '0; bus.cm_wdata = '0;

      // Reset values
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      check("rst_state", state, 2'd0);
      check("rst_count", count, 0);
      check("rst_valid", bus.rd_valid, 1'b0);
      check("rst_last", bus.rd_last, 1'b0);
      check("rst_trig_hit", trig_hit, 1'b0);
      check("rst_data", bus.rd_data, 0);

      // Idle: commits (including trigger matches) are ignored without arm
      trig_pc = 32'h10;
      for (int i = 0; i < 8; i++) begin
         commit((i % 2) ? 32'h10 : 32'(4 * i), 1'b1, 5'd3);
         tick();
         check("idle_state", state, 2'd0);
         check("idle_count", count, 0);
         check("idle_valid", bus.rd_valid, 1'b0);
      end

      // Short capture, trigger on the 5th commit, post_cnt=1
      ready_mode = 0; trig_pc = 32'h10; post_cnt = 5'd1;
      do_arm();
      check("arm_state", state, 2'd1);
      for (int i = 0; i < 5; i++) commit(32'(4 * i), 1'b1, RAW'(i + 1));
      wait_done("short_done");
      check("short_count", count, 5);
      check("short_trig_hit", trig_hit, 1'b1);
      check("short_lat0", bus.rd_valid, 1'b0);
      tick();
      check("short_lat1", bus.rd_valid, 1'b1);
      wait_drain("short_drain");

      // Wrap: 40 commits, trigger at pc 0x80, post_cnt=4 -> last 16 entries
      trig_pc = 32'h80; post_cnt = 5'd4;
      do_arm();
      for (int i = 0; i < 40; i++) commit(32'(4 * i), 1'(i % 2), RAW'(i));
      wait_done("wrap_done");
      check("wrap_count", count, 16);
      check("wrap_trig_hit", trig_hit, 1'b1);
      wait_drain("wrap_drain");

      // Backpressure (toggling) then random ready, random streams and gaps
      for (int t = 0; t < 4; t++) begin
         ready_mode = (t == 0) ? 1 : 2;
         trig_pc = 32'(4 * $urandom_range(0, 15));
         post_cnt = (AW+1)'($urandom_range(0, 31));
         do_arm();
         n = 0;
         while (m_active && n < 400) begin
            commit(32'(4 * $urandom_range(0, 15)), 1'($urandom_range(0, 1)), RAW'($urandom));
            repeat ($urandom_range(0, 2)) tick();
            n++;
         end
         check("rand_model_done", m_active, 1'b0);
         for (int k = 0; k < 3; k++) commit(trig_pc, 1'b1, 5'd7);
         wait_done("rand_done");
         check("rand_count", count, m_buf.size());
         check("rand_trig_hit", trig_hit, 1'b1);
         wait_drain("rand_drain");
      end

      // Arm while TRIGGERED restarts cleanly
      ready_mode = 0; trig_pc = 32'h40; post_cnt = 5'd10;
      do_arm();
      for (int i = 0; i < 20; i++) commit(32'(4 * i), 1'b1, 5'd1);
      check("trg_state", state, 2'd2);
      do_arm();
      check("rearm_state", state, 2'd1);
      check("rearm_count", count, 0);
      check("rearm_valid", bus.rd_valid, 1'b0);
      check("rearm_trig_hit", trig_hit, 1'b0);
      trig_pc = 32'h8; post_cnt = 5'd0;
      for (int i = 0; i < 3; i++) commit(32'(4 * i), 1'b0, 5'd2);
      wait_done("rearm_done");
      check("rearm_count2", count, 3);

      // Arm concurrent with the final transfer
      n = 0;
      while (!(bus.rd_valid && bus.rd_last) && n < 100) begin tick(); n++; end
      check("final_seen", bus.rd_valid && bus.rd_last, 1'b1);
      do_arm();
      check("armfin_state", state, 2'd1);
      check("armfin_count", count, 0);
      check("armfin_valid", bus.rd_valid, 1'b0);
      check("armfin_left", exp_q.size(), 0);

      // rst in the middle of a stalled readout
      ready_mode = 3; trig_pc = 32'h14; post_cnt = 5'd1;
      do_arm();
      for (int i = 0; i < 6; i++) commit(32'(4 * i), 1'b1, 5'd9);
      n = 0;
      while (!bus.rd_valid && n < 50) begin tick(); n++; end
      check("prerst_valid", bus.rd_valid, 1'b1);
      tick(); tick();
      rst = 1'b1;
      tick();
      check("mrst_state", state, 2'd0);
      check("mrst_count", count, 0);
      check("mrst_valid", bus.rd_valid, 1'b0);
      check("mrst_last", bus.rd_last, 1'b0);
      check("mrst_trig_hit", trig_hit, 1'b0);
      check("mrst_data", bus.rd_data, 0);
      rst = 1'b0;
      exp_q.delete();
      m_active = 0;
      ready_mode = 0;
      tick();

`ifdef TRACE_WB_FILTER_EN
      // Write-back filter: only wen && waddr!=0 plus the trigger commit kept
      filt = 1'b1; trig_pc = 32'h34; post_cnt = 5'd3;
      do_arm();
      for (int i = 0; i < 24; i++)
         commit(32'(4 * i), 1'(i % 2 == 0), (i == 4) ? 5'd0 : RAW'(i + 1));
      wait_done("filt_done");
      check("filt_count", count, m_buf.size());
      wait_drain("filt_drain");
      filt = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Synthesizable on-chip successor to the per-cycle register/PC dump bench: captures CPU commit records (pc, instr, register write-back) into a parametrised circular buffer. Arms on request, freezes on a PC-match trigger plus a programmable post-trigger count, then streams entries oldest-first over a valid/ready port. Sits beside the CPU core, fed from the write-back stage, and is read by a debug host or a bench.

Parameters:
XLEN, 32, data/address width of pc, instr, wdata
RAW, 5, register-address width
DEPTH, 16, buffer entries; power of two, >=2
AW, $clog2(DEPTH), pointer width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
arm  in  1  one-cycle pulse: clear buffer and start capture
trig_pc  in  XLEN  PC value that fires the trigger
post_cnt  in  AW+1  entries to keep from trigger onward (trigger entry included)
cm_valid  in  1  a commit occurs this cycle
cm_pc  in  XLEN  committed pc
cm_instr  in  XLEN  committed instruction
cm_wen  in  1  commit writes the register file
cm_waddr  in  RAW  destination register
cm_wdata  in  XLEN  write-back data
rd_ready  in  1  consumer accepts rd_data
rd_valid  out  1  rd_data valid
rd_data  out  2*XLEN+1+RAW+XLEN  {pc, instr, wen, waddr, wdata}
rd_last  out  1  qualifies the final entry of the stream
state  out  2  IDLE=0, ARMED=1, TRIGGERED=2, DONE=3
count  out  AW+1  valid entries held, 0..DEPTH
trig_hit  out  1  sticky: trigger fired since last arm

Behaviour:
- One clock; reset synchronous, active-high. Reset: state=IDLE, wr_ptr=0, count=0, rd_valid=0, rd_last=0, trig_hit=0, rd_data=0.
- IDLE: no capture. arm -> ARMED, wr_ptr=0, count=0, trig_hit=0.
- ARMED: each recorded commit writes at wr_ptr; wr_ptr wraps DEPTH-1 -> 0; count increments, saturating at DEPTH (oldest overwritten).
- Trigger: cm_valid && cm_pc==trig_pc in ARMED. That commit is always recorded; trig_hit<=1; remain<=eff-1 where eff = post_cnt clamped to 1..DEPTH (0 treated as 1). eff==1 -> DONE next cycle, else TRIGGERED.
- TRIGGERED: each recorded commit decrements remain; the write that makes remain 0 moves to DONE. Further pc matches are ignored.
- DONE: capture frozen. Read pointer = (count==DEPTH) ? wr_ptr : 0. Synchronous RAM read prefetches, so rd_valid rises 1 cycle after entering DONE (never when count==0). Transfer on rd_valid && rd_ready; the next entry is presented the following cycle (one bubble max). rd_data/rd_last hold stable while rd_valid && !rd_ready. rd_last=1 on the count-th entry. After the last transfer, rd_valid=0 and the state stays DONE.
- arm in any state restarts capture (ARMED, cleared); arm beats a simultaneous commit, trigger or read transfer. Any in-flight rd_valid drops the next cycle.
- rst mid-capture or mid-readout: immediate return to reset values. RAM contents are don't-care.
- cm_valid ignored in IDLE/DONE. Commit inputs sampled only when cm_valid=1.

Optional Feature:
TRACE_WB_FILTER_EN: adds input filt_wb_only (1 bit). When filt_wb_only=1, only commits with cm_wen && cm_waddr!=0 are recorded and counted toward post_cnt; the trigger is still evaluated on every commit, and the trigger commit is always recorded. Without the macro the port is absent and every commit is recorded.

Decomposition:
- Package trace_pkg: state encoding constants, ENTRY_W function of XLEN/RAW, field bit offsets for rd_data, entry pack/unpack functions.
- Sub-module trace_ram: simple dual-port RAM, DEPTH x ENTRY_W, one write port, registered read. Control FSM, pointers and readout live in cpu_trace_buffer.

Test Plan:
- Reset then idle: cm_valid toggling, no arm -> state=0, count=0, rd_valid=0 throughout.
- DEPTH=16, arm, 5 commits pc=0x00..0x10, trigger at pc=0x10, post_cnt=1 -> DONE, count=5, stream pc 0x00,0x04,0x08,0x0C,0x10; rd_last only on 0x10.
- Wrap: 40 commits pc=4*i, trigger pc=0x80 (i=32), post_cnt=4 -> count=16, stream pc=0x50..0x8C oldest-first, trig_hit=1.
- Backpressure: rd_ready toggling 1/0 every cycle -> each entry delivered exactly once, rd_data stable while stalled.
- Arm during TRIGGERED and arm concurrent with the final transfer -> state=ARMED, count=0, rd_valid=0 the next cycle. rst asserted mid-readout -> all reset values.
- With TRACE_WB_FILTER_EN and filt_wb_only=1: commits alternate wen=1/0 plus one waddr=0 write -> only wen=1, waddr!=0 entries plus the trigger entry are recorded.
